// File: rtl/serial_sub.sv
// Bit-serial LSB-first subtractor: one full-subtractor cell, one borrow flop.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_sub #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
   output logic             ovf,
`endif
   output logic             borrow
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic             brw_q, brw_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_q, borrow_d;
   logic             d_bit, bout;
   logic             last;

`ifdef SERIAL_SUB_OVF_EN
   logic a_msb_q, a_msb_d;
   logic b_msb_q, b_msb_d;
   logic ovf_q, ovf_d;
`endif

   // Result bits enter at the top of the minuend register as its LSBs retire.
   always_comb begin
      d_bit = a_sh_q[0] ^ b_sh_q[0] ^ brw_q;
      bout  = (~a_sh_q[0] & b_sh_q[0])
            | (~(a_sh_q[0] ^ b_sh_q[0]) & brw_q);
      last  = (cnt_q == CW'(WIDTH - 1));
   end

   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      brw_d    = brw_q;
      cnt_d    = cnt_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_d  = a_msb_q;
      b_msb_d  = b_msb_q;
      ovf_d    = ovf_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_SHIFT;
               a_sh_d  = a;
               b_sh_d  = b;
               brw_d   = 1'b0;
               cnt_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
               a_msb_d = a[WIDTH-1];
               b_msb_d = b[WIDTH-1];
`endif
            end
         end
         S_SHIFT: begin
            a_sh_d = {d_bit, a_sh_q[WIDTH-1:1]};
            b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
            brw_d  = bout;
            cnt_d  = cnt_q + 1'b1;
            if (last) begin
               state_d  = S_DONE;
               diff_d   = {d_bit, a_sh_q[WIDTH-1:1]};
               borrow_d = bout;
`ifdef SERIAL_SUB_OVF_EN
               ovf_d    = (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
`endif
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         brw_q    <= 1'b0;
         cnt_q    <= '0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         brw_q    <= brw_d;
         cnt_q    <= cnt_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
      end
   end

`ifdef SERIAL_SUB_OVF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         a_msb_q <= a_msb_d;
         b_msb_q <= b_msb_d;
         ovf_q   <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`endif

   assign busy   = (state_q == S_SHIFT);
   assign done   = (state_q == S_DONE);
   assign diff   = diff_q;
   assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_sub.sv
// Directed and random checks for serial_sub at WIDTH=8.
// Build with SERIAL_SUB_OVF_EN defined to also exercise the ovf output.
module tb_serial_sub;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       busy;
   logic       done;
   logic [7:0] diff;
   logic       borrow;
`ifdef SERIAL_SUB_OVF_EN
   logic       ovf;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   serial_sub #(.WIDTH(8)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .diff   (diff),
`ifdef SERIAL_SUB_OVF_EN
      .ovf    (ovf),
`endif
      .borrow (borrow)
   );

   // Launch one operation and wait (bounded) for its done pulse.
   task automatic do_op(input logic [7:0] av, input logic [7:0] bv,
                        output logic [7:0] d, output logic br,
                        output int lat, output int bcnt);
      lat  = 0;
      bcnt = 0;
      @(negedge clk);
      a = av;
      b = bv;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int n = 1; n <= 30; n++) begin
         @(negedge clk);
         if (busy) bcnt++;
         if (done) begin
            lat = n;
            break;
         end
      end
      d  = diff;
      br = borrow;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b0;
      a = 8'h00;
      b = 8'h00;
      #12;
      total++;
      if ({busy, done, diff, borrow} !== 11'd0) begin
         bad++;
         $display("FAIL reset_outputs: got busy=%b done=%b diff=%h borrow=%b want all 0",
                  busy, done, diff, borrow);
      end
`ifdef SERIAL_SUB_OVF_EN
      total++;
      if (ovf !== 1'b0) begin
         bad++;
         $display("FAIL reset_ovf: got %b want 0", ovf);
      end
`endif
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic();
      logic [7:0] va [5] = '{8'h05, 8'h03, 8'h00, 8'hFF, 8'h00};
      logic [7:0] vb [5] = '{8'h03, 8'h05, 8'h00, 8'hFF, 8'h01};
      logic [7:0] vd [5] = '{8'h02, 8'hFE, 8'h00, 8'h00, 8'hFF};
      logic       vr [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [7:0] d;
      logic       br;
      int         lat, bcnt;
      for (int i = 0; i < 5; i++) begin
         do_op(va[i], vb[i], d, br, lat, bcnt);
         total++;
         if (lat !== 9) begin
            bad++;
            $display("FAIL basic%0d_latency: got %0d want 9", i, lat);
         end
         total++;
         if (d !== vd[i] || br !== vr[i]) begin
            bad++;
            $display("FAIL basic%0d_result: got diff=%h borrow=%b want diff=%h borrow=%b",
                     i, d, br, vd[i], vr[i]);
         end
         if (i == 0) begin
            total++;
            if (bcnt !== 8) begin
               bad++;
               $display("FAIL basic_busy_cycles: got %0d want 8", bcnt);
            end
            total++;
            if (busy !== 1'b0) begin
               bad++;
               $display("FAIL busy_with_done: got busy=%b want 0", busy);
            end
         end
      end
   endtask

`ifdef SERIAL_SUB_OVF_EN
   task automatic test_ovf();
      logic [7:0] va [3] = '{8'h80, 8'h7F, 8'h10};
      logic [7:0] vb [3] = '{8'h01, 8'hFF, 8'h01};
      logic [7:0] vd [3] = '{8'h7F, 8'h80, 8'h0F};
      logic       vr [3] = '{1'b0, 1'b1, 1'b0};
      logic       vo [3] = '{1'b1, 1'b1, 1'b0};
      logic [7:0] d;
      logic       br;
      int         lat, bcnt;
      for (int i = 0; i < 3; i++) begin
         do_op(va[i], vb[i], d, br, lat, bcnt);
         total++;
         if (d !== vd[i] || br !== vr[i] || ovf !== vo[i] || lat !== 9) begin
            bad++;
            $display("FAIL ovf%0d: got diff=%h borrow=%b ovf=%b lat=%0d want %h %b %b 9",
                     i, d, br, ovf, lat, vd[i], vr[i], vo[i]);
         end
      end
   endtask
`endif

   task automatic test_start_during_busy();
      int         ndone = 0;
      logic [7:0] dsave = 8'hXX;
      @(negedge clk);
      a = 8'h05;
      b = 8'h03;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int n = 1; n <= 25; n++) begin
         @(negedge clk);
         if (n == 3) begin
            a = 8'h0A;
            b = 8'h01;
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (done) begin
            ndone++;
            dsave = diff;
         end
      end
      total++;
      if (ndone !== 1) begin
         bad++;
         $display("FAIL busy_start_count: got %0d done pulses want 1", ndone);
      end
      total++;
      if (dsave !== 8'h02) begin
         bad++;
         $display("FAIL busy_start_diff: got %h want 02", dsave);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] d;
      logic       br;
      int         lat, bcnt;
      do_op(8'h44, 8'h11, d, br, lat, bcnt);
      do_op(8'h20, 8'h10, d, br, lat, bcnt);
      total++;
      if (lat !== 9 || d !== 8'h10 || br !== 1'b0) begin
         bad++;
         $display("FAIL back_to_back: got diff=%h borrow=%b lat=%0d want 10 0 9",
                  d, br, lat);
      end
   endtask

   task automatic test_input_stability();
      logic [7:0] dsave = 8'hXX;
      logic       bsave = 1'bX;
      @(negedge clk);
      a = 8'h37;
      b = 8'h15;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int n = 1; n <= 30; n++) begin
         @(negedge clk);
         a = 8'($urandom);
         b = 8'($urandom);
         if (done) begin
            dsave = diff;
            bsave = borrow;
            break;
         end
      end
      total++;
      if (dsave !== 8'h22 || bsave !== 1'b0) begin
         bad++;
         $display("FAIL input_stability: got diff=%h borrow=%b want 22 0",
                  dsave, bsave);
      end
   endtask

   task automatic test_reset_mid();
      int         ndone = 0;
      logic [7:0] d;
      logic       br;
      int         lat, bcnt;
      @(negedge clk);
      a = 8'h05;
      b = 8'h03;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      total++;
      if ({busy, done, diff, borrow} !== 11'd0) begin
         bad++;
         $display("FAIL reset_mid_outputs: got busy=%b done=%b diff=%h borrow=%b want all 0",
                  busy, done, diff, borrow);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int n = 0; n < 15; n++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      total++;
      if (ndone !== 0) begin
         bad++;
         $display("FAIL reset_mid_no_done: got %0d pulses want 0", ndone);
      end
      do_op(8'h09, 8'h04, d, br, lat, bcnt);
      total++;
      if (d !== 8'h05 || br !== 1'b0 || lat !== 9) begin
         bad++;
         $display("FAIL reset_mid_resume: got diff=%h borrow=%b lat=%0d want 05 0 9",
                  d, br, lat);
      end
   endtask

   task automatic test_random();
      logic [7:0] av, bv, d, ed;
      logic       br, eb;
      int         lat, bcnt;
      for (int i = 0; i < 1000; i++) begin
         av = 8'($urandom);
         bv = 8'($urandom);
         ed = av - bv;
         eb = (av < bv);
         do_op(av, bv, d, br, lat, bcnt);
         total++;
         if (d !== ed || br !== eb || lat !== 9) begin
            bad++;
            $display("FAIL random%0d %h-%h: got diff=%h borrow=%b lat=%0d want %h %b 9",
                     i, av, bv, d, br, lat, ed, eb);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
`ifdef SERIAL_SUB_OVF_EN
      test_ovf();
`endif
      test_start_during_busy();
      test_back_to_back();
      test_input_stability();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
